// File: rtl/hdlc_rx_arb_pkg.sv
// Shared constants, entry layout and arbiter state encoding for the HDLC receive arbiter.
// Each FIFO entry is {abort, last, data}.
package hdlc_rx_arb_pkg;

    localparam int FIFO_DEPTH_DEF = 64;
    localparam int ENTRY_W        = 10;
    localparam int ABORT_BIT      = 9;
    localparam int LAST_BIT       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(input logic abort,
                                                      input logic last,
                                                      input logic [7:0] data);
        return {abort, last, data};
    endfunction

endpackage

// File: rtl/hdlc_rx_arb_fifo.sv
// Synchronous first-word-fall-through byte FIFO with a registered head entry.
// A write to a full FIFO is dropped even when a read happens in the same cycle.
module hdlc_byte_fifo
    import hdlc_rx_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_wr      = wr_en && !full;
    assign do_rd      = rd_en && !empty;
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The head is loaded from the write port when the incoming entry becomes the oldest one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_wr && (count == '0 || (do_rd && count == CW'(1)))) begin
                head <= wr_data;
            end else if (do_rd && count > CW'(1)) begin
                head <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/hdlc_rx_arb.sv
// Merges two HDLC receiver byte streams into one frame-atomic stream with
// round-robin arbitration, per-channel overflow flags and a completed-frame counter.
module hdlc_rx_arb
    import hdlc_rx_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ch0_tvalid,
    input  logic [7:0]  ch0_tdata,
    input  logic        ch0_tlast,
    input  logic        ch0_finish,
    input  logic        ch1_tvalid,
    input  logic [7:0]  ch1_tdata,
    input  logic        ch1_tlast,
    input  logic        ch1_finish,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic [1:0]  m_tuser,
    output logic [1:0]  ovf,
    input  logic        clr_ovf,
    output logic [15:0] frame_cnt
);

    logic [1:0]         in_valid;
    logic [1:0]         in_last;
    logic [1:0]         in_finish;
    logic [7:0]         in_data    [2];
    logic [1:0]         fifo_wr;
    logic [1:0]         fifo_rd;
    logic [1:0]         fifo_full;
    logic [1:0]         fifo_empty;
    logic [1:0]         ovf_set;
    logic [ENTRY_W-1:0] fifo_wdata [2];
    logic [ENTRY_W-1:0] fifo_head  [2];

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_srv_q;
    logic       sel;
    logic       frame_done;

    assign in_valid   = {ch1_tvalid, ch0_tvalid};
    assign in_last    = {ch1_tlast, ch0_tlast};
    assign in_finish  = {ch1_finish, ch0_finish};
    assign in_data[0] = ch0_tdata;
    assign in_data[1] = ch1_tdata;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic open_q;
        logic pend_q;
        logic abort_now;

        assign abort_now     = !in_valid[g] && (pend_q || (in_finish[g] && open_q));
        assign fifo_wr[g]    = in_valid[g] || abort_now;
        assign fifo_wdata[g] = in_valid[g] ? make_entry(1'b0, in_last[g], in_data[g])
                                           : make_entry(1'b1, 1'b1, 8'h00);
        assign ovf_set[g]    = fifo_wr[g] && fifo_full[g];

        // A finish that collides with a byte is deferred; it keeps retrying until it fits in the FIFO.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                open_q <= 1'b0;
                pend_q <= 1'b0;
            end else if (in_valid[g]) begin
                pend_q <= !in_last[g] && (in_finish[g] || pend_q);
                if (!fifo_full[g]) begin
                    open_q <= !in_last[g];
                end
            end else if (abort_now && !fifo_full[g]) begin
                open_q <= 1'b0;
                pend_q <= 1'b0;
            end
        end

        hdlc_byte_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (fifo_wr[g]),
            .wr_data (fifo_wdata[g]),
            .rd_en   (fifo_rd[g]),
            .head    (fifo_head[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 2'b00;
        end else if (clr_ovf) begin
            ovf <= ovf_set;
        end else begin
            ovf <= ovf | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_srv_q <= 1'b1;
            frame_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (frame_done) begin
                last_srv_q <= sel;
                frame_cnt  <= frame_cnt + 1'b1;
            end
        end
    end

    // The grant stays on one channel until its tlast beat is accepted, even if that FIFO runs dry.
    always_comb begin
        state_d    = state_q;
        sel        = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = 8'h00;
        m_tlast    = 1'b0;
        m_tuser    = 2'b00;
        fifo_rd    = 2'b00;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty[0] && !fifo_empty[1]) begin
                    state_d = last_srv_q ? GRANT0 : GRANT1;
                end else if (!fifo_empty[0]) begin
                    state_d = GRANT0;
                end else if (!fifo_empty[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                sel      = (state_q == GRANT1);
                m_tvalid = !fifo_empty[sel];
                m_tdata  = fifo_head[sel][7:0];
                m_tlast  = fifo_head[sel][LAST_BIT];
                m_tuser  = {fifo_head[sel][ABORT_BIT], sel};
                if (m_tvalid && m_tready) begin
                    fifo_rd = sel ? 2'b10 : 2'b01;
                    if (m_tlast) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hdlc_rx_arb.sv
// Directed scoreboard bench for hdlc_rx_arb: expected beats are queued as stimulus is driven
// and compared beat by beat when the merged stream hands them off.
module tb_hdlc_rx_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ch0_tvalid = 1'b0, ch0_tlast = 1'b0, ch0_finish = 1'b0;
    logic        ch1_tvalid = 1'b0, ch1_tlast = 1'b0, ch1_finish = 1'b0;
    logic [7:0]  ch0_tdata = 8'h00, ch1_tdata = 8'h00;
    logic        m_tready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        m_tvalid, m_tlast;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tuser, ovf;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;
    logic [10:0] exp_q [$];

    always #5 clk = ~clk;

    hdlc_rx_arb #(.FIFO_DEPTH(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ch0_tvalid (ch0_tvalid),
        .ch0_tdata  (ch0_tdata),
        .ch0_tlast  (ch0_tlast),
        .ch0_finish (ch0_finish),
        .ch1_tvalid (ch1_tvalid),
        .ch1_tdata  (ch1_tdata),
        .ch1_tlast  (ch1_tlast),
        .ch1_finish (ch1_finish),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf),
        .frame_cnt  (frame_cnt)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic [1:0] u);
        exp_q.push_back({d, l, u});
        if (l) exp_frames++;
    endtask

    task automatic apply_stimulus(input int ch, input logic v, input logic [7:0] d,
                                  input logic l, input logic f);
        if (ch == 0) begin
            ch0_tvalid = v; ch0_tdata = d; ch0_tlast = l; ch0_finish = f;
        end else begin
            ch1_tvalid = v; ch1_tdata = d; ch1_tlast = l; ch1_finish = f;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        apply_stimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
        clr_ovf = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output(tag, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check_output({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        check_output({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check_output({tag, "_tuser"}, 32'(m_tuser), 32'd0);
        check_output({tag, "_ovf"}, 32'(ovf), 32'd0);
        check_output({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL sb_extra: observed beat %0h expected none", {m_tdata, m_tlast, m_tuser});
            end
            if (exp_q.size() != 0) begin
                check_output("beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_tready = 1'b1;
        tick();

        $display("[TB] simultaneous frames, ch0 first after reset");
        for (int i = 0; i < 4; i++) expect_beat(8'hA0 + 8'(i), i == 3, 2'b00);
        for (int i = 0; i < 4; i++) expect_beat(8'hB0 + 8'(i), i == 3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, 8'hA0 + 8'(i), i == 3, 1'b0);
            apply_stimulus(1, 1'b1, 8'hB0 + 8'(i), i == 3, 1'b0);
            tick();
        end
        wait_drain("drain_rr", 100);
        check_output("frame_cnt_rr", 32'(frame_cnt), 32'(exp_frames));

        $display("[TB] three-byte frame with latency probe");
        expect_beat(8'h01, 1'b0, 2'b00);
        expect_beat(8'h02, 1'b0, 2'b00);
        expect_beat(8'h03, 1'b1, 2'b00);
        apply_stimulus(0, 1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        apply_stimulus(0, 1'b1, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check_output("lat_idle", 32'(m_tvalid), 32'd0);
        tick();
        apply_stimulus(0, 1'b1, 8'h03, 1'b1, 1'b0);
        @(negedge clk);
        check_output("lat_grant", 32'(m_tvalid), 32'd1);
        tick();
        wait_drain("drain_basic", 50);
        check_output("frame_cnt_basic", 32'(frame_cnt), 32'(exp_frames));

        $display("[TB] ch1 frame closed by finish");
        expect_beat(8'hC1, 1'b0, 2'b01);
        expect_beat(8'hC2, 1'b0, 2'b01);
        expect_beat(8'h00, 1'b1, 2'b11);
        apply_stimulus(1, 1'b1, 8'hC1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1, 1'b1, 8'hC2, 1'b0, 1'b0);
        tick();
        apply_stimulus(1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        wait_drain("drain_abort", 50);

        $display("[TB] finish colliding with a byte on ch0");
        expect_beat(8'hD1, 1'b0, 2'b00);
        expect_beat(8'h00, 1'b1, 2'b10);
        apply_stimulus(0, 1'b1, 8'hD1, 1'b0, 1'b1);
        tick();
        tick();
        wait_drain("drain_collide", 50);
        check_output("frame_cnt_abort", 32'(frame_cnt), 32'(exp_frames));

        $display("[TB] overflow with stalled output");
        m_tready = 1'b0;
        for (int i = 0; i < 64; i++) expect_beat(8'h40 + 8'(i), 1'b0, 2'b00);
        for (int i = 0; i < 70; i++) begin
            apply_stimulus(0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        check_output("ovf_set", 32'(ovf), 32'd1);
        @(negedge clk);
        check_output("stall_valid", 32'(m_tvalid), 32'd1);
        check_output("stall_hold", 32'(m_tdata), 32'h40);
        tick();
        apply_stimulus(0, 1'b1, 8'hFF, 1'b0, 1'b0);
        clr_ovf = 1'b1;
        tick();
        check_output("ovf_set_wins", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        check_output("ovf_clr", 32'(ovf), 32'd0);
        m_tready = 1'b1;
        wait_drain("drain_ovf", 200);
        expect_beat(8'h00, 1'b1, 2'b10);
        apply_stimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        wait_drain("drain_ovf_close", 50);
        check_output("frame_cnt_ovf", 32'(frame_cnt), 32'(exp_frames));

        $display("[TB] toggling ready on a ch1 frame");
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) expect_beat(8'hE0 + 8'(i), i == 4, 2'b01);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 1'b1, 8'hE0 + 8'(i), i == 4, 1'b0);
            tick();
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            m_tready = (i % 2 == 0);
            @(negedge clk);
            if (m_tvalid && !m_tready && exp_q.size() != 0) begin
                check_output("stall_data", 32'({m_tdata, m_tlast, m_tuser}), 32'(exp_q[0]));
            end
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        wait_drain("drain_toggle", 50);
        check_output("frame_cnt_toggle", 32'(frame_cnt), 32'(exp_frames));

        $display("[TB] reset in the middle of a buffered frame");
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        tick();
        check_output("pre_reset_valid", 32'(m_tvalid), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_tready = 1'b1;
        expect_beat(8'h70, 1'b0, 2'b00);
        expect_beat(8'h71, 1'b0, 2'b00);
        expect_beat(8'h72, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 1'b1, 8'h70 + 8'(i), i == 2, 1'b0);
            tick();
        end
        wait_drain("drain_post_rst", 50);
        check_output("frame_cnt_post_rst", 32'(frame_cnt), 32'(exp_frames));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
